// File: rtl/fb_pkg.sv
// Shared constants, FSM state encoding and the draw bounds helper for the
// framebuffer access arbiter.
package fb_pkg;

  localparam int H_PIXELS            = 128;
  localparam int V_PIXELS            = 64;
  localparam int TIMEOUT_CYC_DEFAULT = 31;

  typedef enum logic [2:0] {
    INIT_RST,
    INIT_WAIT,
    IDLE,
    READ,
    WRITE,
    ACK
  } arb_state_t;

  typedef enum logic {
    GRANT_SCAN = 1'b0,
    GRANT_DRAW = 1'b1
  } grant_t;

  function automatic logic draw_in_bounds(input logic [7:0] x, input logic [7:0] y);
    return (int'(x) < H_PIXELS) && (int'(y) < V_PIXELS);
  endfunction

endpackage

// File: rtl/fb_access_arbiter.sv
// Arbitrates a scan reader and a draw writer onto one framebuffer port,
// sequencing framebuffer reset, round-robin grants and a transfer timeout.
module fb_access_arbiter
  import fb_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  output logic       fb_rst,
  input  logic       fb_rst_complete,
  output logic       fb_we,
  input  logic       fb_w_data_valid,
  output logic [7:0] fb_w_xpos,
  output logic [7:0] fb_w_ypos,
  output logic [7:0] fb_din,
  output logic       fb_re,
  input  logic       fb_r_data_valid,
  input  logic [7:0] fb_dout,
  output logic [7:0] fb_r_xpos,
  output logic [7:0] fb_r_ypos,
  output logic       fb_r_mode,
  input  logic       scan_req,
  input  logic [7:0] scan_xpos,
  input  logic [7:0] scan_ypos,
  input  logic       scan_mode,
  output logic       scan_ack,
  output logic [7:0] scan_data,
  input  logic       draw_req,
  input  logic [7:0] draw_xpos,
  input  logic [7:0] draw_ypos,
  input  logic [7:0] draw_din,
  output logic       draw_ack,
  output logic       draw_rej,
  output logic       ready,
  output logic       err
);

  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_t state_q, state_d;
  grant_t     last_q, last_d;
  logic [7:0] x_q, x_d, y_q, y_d, din_q, din_d;
  logic       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] scan_data_q, scan_data_d;
  logic       ready_q, ready_d, err_q, err_d;
  logic       fb_rst_q, fb_rst_d, fb_re_q, fb_re_d, fb_we_q, fb_we_d;
  logic       scan_ack_q, scan_ack_d, draw_ack_q, draw_ack_d, draw_rej_q, draw_rej_d;

  logic grant_scan, grant_draw;

  // Under contention the requester that was not served last wins.
  assign grant_scan = scan_req && (!draw_req || (last_q == GRANT_DRAW));
  assign grant_draw = draw_req && !grant_scan;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    x_d         = x_q;
    y_d         = y_q;
    din_d       = din_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    scan_data_d = scan_data_q;
    ready_d     = ready_q;
    err_d       = err_q;
    fb_rst_d    = 1'b0;
    fb_re_d     = 1'b0;
    fb_we_d     = 1'b0;
    scan_ack_d  = 1'b0;
    draw_ack_d  = 1'b0;
    draw_rej_d  = 1'b0;

    case (state_q)
      INIT_RST: begin
        fb_rst_d = 1'b1;
        state_d  = INIT_WAIT;
      end
      INIT_WAIT: begin
        if (fb_rst_complete) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (grant_scan) begin
          last_d  = GRANT_SCAN;
          x_d     = scan_xpos;
          y_d     = scan_ypos;
          mode_d  = scan_mode;
          cnt_d   = '0;
          fb_re_d = 1'b1;
          state_d = READ;
        end else if (grant_draw) begin
          last_d = GRANT_DRAW;
          if (draw_in_bounds(draw_xpos, draw_ypos)) begin
            x_d     = draw_xpos;
            y_d     = draw_ypos;
            din_d   = draw_din;
            cnt_d   = '0;
            fb_we_d = 1'b1;
            state_d = WRITE;
          end else begin
            // Off-screen draws are answered without touching the framebuffer.
            draw_ack_d = 1'b1;
            draw_rej_d = 1'b1;
            state_d    = ACK;
          end
        end
      end
      READ: begin
        if (fb_r_data_valid) begin
          scan_data_d = fb_dout;
          scan_ack_d  = 1'b1;
          state_d     = ACK;
        end else if (cnt_q == CNT_LAST) begin
          err_d       = 1'b1;
          scan_data_d = 8'h00;
          scan_ack_d  = 1'b1;
          state_d     = ACK;
        end else begin
          fb_re_d = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      WRITE: begin
        if (fb_w_data_valid) begin
          draw_ack_d = 1'b1;
          state_d    = ACK;
        end else if (cnt_q == CNT_LAST) begin
          err_d      = 1'b1;
          draw_ack_d = 1'b1;
          state_d    = ACK;
        end else begin
          fb_we_d = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ACK: begin
        // Strobes are already low here, giving the framebuffer an idle cycle.
        state_d = IDLE;
      end
      default: begin
        state_d = INIT_RST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT_RST;
      last_q      <= GRANT_DRAW;
      x_q         <= 8'h00;
      y_q         <= 8'h00;
      din_q       <= 8'h00;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      scan_data_q <= 8'h00;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      fb_rst_q    <= 1'b0;
      fb_re_q     <= 1'b0;
      fb_we_q     <= 1'b0;
      scan_ack_q  <= 1'b0;
      draw_ack_q  <= 1'b0;
      draw_rej_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      x_q         <= x_d;
      y_q         <= y_d;
      din_q       <= din_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      scan_data_q <= scan_data_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      fb_rst_q    <= fb_rst_d;
      fb_re_q     <= fb_re_d;
      fb_we_q     <= fb_we_d;
      scan_ack_q  <= scan_ack_d;
      draw_ack_q  <= draw_ack_d;
      draw_rej_q  <= draw_rej_d;
    end
  end

  assign fb_rst    = fb_rst_q;
  assign fb_re     = fb_re_q;
  assign fb_we     = fb_we_q;
  assign fb_w_xpos = x_q;
  assign fb_w_ypos = y_q;
  assign fb_din    = din_q;
  assign fb_r_xpos = x_q;
  assign fb_r_ypos = y_q;
  assign fb_r_mode = mode_q;
  assign scan_ack  = scan_ack_q;
  assign scan_data = scan_data_q;
  assign draw_ack  = draw_ack_q;
  assign draw_rej  = draw_rej_q;
  assign ready     = ready_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Scoreboard bench for fb_access_arbiter with a behavioural framebuffer model
// that answers reset, read and write strobes with programmable latency.
module tb_fb_access_arbiter;
  import fb_pkg::*;

  localparam int RST_LAT = 1024;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] d;
    logic       m;
    logic       rej;
  } item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fb_rst, fb_we, fb_re, fb_r_mode;
  logic       fb_rst_complete = 1'b0;
  logic       fb_w_data_valid = 1'b0;
  logic       fb_r_data_valid = 1'b0;
  logic [7:0] fb_dout = 8'h00;
  logic [7:0] fb_w_xpos, fb_w_ypos, fb_din, fb_r_xpos, fb_r_ypos;
  logic       scan_req = 1'b0, scan_mode = 1'b0;
  logic [7:0] scan_xpos = 8'h00, scan_ypos = 8'h00;
  logic       scan_ack;
  logic [7:0] scan_data;
  logic       draw_req = 1'b0;
  logic [7:0] draw_xpos = 8'h00, draw_ypos = 8'h00, draw_din = 8'h00;
  logic       draw_ack, draw_rej, ready, err;

  always #5 clk = ~clk;

  fb_access_arbiter #(.TIMEOUT_CYC(31)) dut (
    .clk(clk), .rst(rst),
    .fb_rst(fb_rst), .fb_rst_complete(fb_rst_complete),
    .fb_we(fb_we), .fb_w_data_valid(fb_w_data_valid),
    .fb_w_xpos(fb_w_xpos), .fb_w_ypos(fb_w_ypos), .fb_din(fb_din),
    .fb_re(fb_re), .fb_r_data_valid(fb_r_data_valid), .fb_dout(fb_dout),
    .fb_r_xpos(fb_r_xpos), .fb_r_ypos(fb_r_ypos), .fb_r_mode(fb_r_mode),
    .scan_req(scan_req), .scan_xpos(scan_xpos), .scan_ypos(scan_ypos),
    .scan_mode(scan_mode), .scan_ack(scan_ack), .scan_data(scan_data),
    .draw_req(draw_req), .draw_xpos(draw_xpos), .draw_ypos(draw_ypos),
    .draw_din(draw_din), .draw_ack(draw_ack), .draw_rej(draw_rej),
    .ready(ready), .err(err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input logic [7:0] x, input logic [7:0] y, input logic m);
    return x ^ {y[6:0], 1'b0} ^ {7'b0, m};
  endfunction

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Framebuffer model
  int         rd_lat = 10, wr_lat = 4;
  bit         rd_never = 0, wr_never = 0, rd_force = 0;
  logic [7:0] rd_force_val = 8'h00;
  int         rd_cnt = 0, wr_cnt = 0, rstc_cnt = -1, complete_cyc = 0;

  initial forever begin
    @(negedge clk);
    fb_r_data_valid = 1'b0;
    fb_w_data_valid = 1'b0;
    if (rst) begin
      fb_rst_complete = 1'b0;
      rstc_cnt = -1;
    end else if (fb_rst) begin
      fb_rst_complete = 1'b0;
      rstc_cnt = 0;
    end else if (rstc_cnt >= 0) begin
      rstc_cnt++;
      if (rstc_cnt == RST_LAT) begin
        fb_rst_complete = 1'b1;
        complete_cyc = cyc;
        rstc_cnt = -1;
      end
    end
    if (fb_re) begin
      rd_cnt++;
      if (!rd_never && rd_cnt == rd_lat) begin
        fb_r_data_valid = 1'b1;
        fb_dout = rd_force ? rd_force_val : pix(fb_r_xpos, fb_r_ypos, fb_r_mode);
      end
    end else begin
      rd_cnt = 0;
    end
    if (fb_we) begin
      wr_cnt++;
      if (!wr_never && wr_cnt == wr_lat) fb_w_data_valid = 1'b1;
    end else begin
      wr_cnt = 0;
    end
  end

  // Scoreboard and monitor
  item_t scan_q[$];
  item_t draw_q[$];
  bit    grant_log[$];
  logic  prev_strobe = 0, prev_sack = 0, prev_dack = 0, prev_fbrst = 0, prev_ready = 0;
  bit    had_strobe = 0;
  int    run_len = 0, last_run = 0, gap = 0, we_rises = 0, draw_acks = 0;
  int    fb_rst_len = 0, fb_rst_last_len = 0, fb_rst_pulses = 0, ready_cyc = 0;

  initial forever begin
    item_t it;
    logic  strobe;
    @(negedge clk);
    strobe = fb_re | fb_we;
    check_val("re_we_excl", 64'(fb_re & fb_we), 64'd0);
    if (strobe) begin
      if (!prev_strobe) begin
        if (had_strobe) check_val("strobe_gap", 64'(gap >= 1), 64'd1);
        had_strobe = 1;
        gap = 0;
        run_len = 0;
        if (fb_re) begin
          grant_log.push_back(1'b0);
          check_val("scan_pending_at_re", 64'(scan_q.size() != 0), 64'd1);
          if (scan_q.size() != 0) begin
            check_val("re_xpos", 64'(fb_r_xpos), 64'(scan_q[0].x));
            check_val("re_ypos", 64'(fb_r_ypos), 64'(scan_q[0].y));
            check_val("re_mode", 64'(fb_r_mode), 64'(scan_q[0].m));
          end
        end
        if (fb_we) begin
          grant_log.push_back(1'b1);
          we_rises++;
          check_val("draw_pending_at_we", 64'(draw_q.size() != 0), 64'd1);
          if (draw_q.size() != 0) begin
            check_val("we_xpos", 64'(fb_w_xpos), 64'(draw_q[0].x));
            check_val("we_ypos", 64'(fb_w_ypos), 64'(draw_q[0].y));
            check_val("we_din", 64'(fb_din), 64'(draw_q[0].d));
          end
        end
      end
      run_len++;
    end else begin
      if (prev_strobe) last_run = run_len;
      gap++;
    end
    if (scan_ack) begin
      check_val("scan_ack_pulse", 64'(prev_sack), 64'd0);
      check_val("acks_exclusive", 64'(draw_ack), 64'd0);
      check_val("scan_ack_expected", 64'(scan_q.size() != 0), 64'd1);
      if (scan_q.size() != 0) begin
        it = scan_q.pop_front();
        check_val("scan_data", 64'(scan_data), 64'(it.d));
      end
    end
    if (draw_ack) begin
      draw_acks++;
      check_val("draw_ack_pulse", 64'(prev_dack), 64'd0);
      check_val("draw_ack_expected", 64'(draw_q.size() != 0), 64'd1);
      if (draw_q.size() != 0) begin
        it = draw_q.pop_front();
        check_val("draw_rej", 64'(draw_rej), 64'(it.rej));
      end
    end
    if (fb_rst) begin
      fb_rst_len++;
    end else if (prev_fbrst) begin
      fb_rst_pulses++;
      fb_rst_last_len = fb_rst_len;
      fb_rst_len = 0;
    end
    if (ready && !prev_ready) ready_cyc = cyc;
    prev_strobe = strobe;
    prev_sack   = scan_ack;
    prev_dack   = draw_ack;
    prev_fbrst  = fb_rst;
    prev_ready  = ready;
  end

  // Requesters
  task automatic scan_go(input logic [7:0] x, input logic [7:0] y, input logic m,
                         input logic [7:0] exp);
    item_t it;
    it.x = x; it.y = y; it.d = exp; it.m = m; it.rej = 1'b0;
    scan_q.push_back(it);
    scan_xpos = x; scan_ypos = y; scan_mode = m; scan_req = 1'b1;
  endtask

  task automatic draw_go(input logic [7:0] x, input logic [7:0] y, input logic [7:0] d);
    item_t it;
    it.x = x; it.y = y; it.d = d; it.m = 1'b0;
    it.rej = !(x < 8'd128 && y < 8'd64);
    draw_q.push_back(it);
    draw_xpos = x; draw_ypos = y; draw_din = d; draw_req = 1'b1;
  endtask

  task automatic wait_scan(output int lat);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (scan_ack) begin
        scan_req = 1'b0;
        lat = i + 1;
        break;
      end
    end
    if (lat < 0) check_val("scan_ack_seen", 64'(scan_ack), 64'd1);
  endtask

  task automatic wait_draw(output int lat);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (draw_ack) begin
        draw_req = 1'b0;
        lat = i + 1;
        break;
      end
    end
    if (lat < 0) check_val("draw_ack_seen", 64'(draw_ack), 64'd1);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    fb_rst_pulses = 0;
    @(negedge clk);
    check_val("rst_ctrl_zero",
              64'({fb_rst, fb_re, fb_we, scan_ack, draw_ack, draw_rej, ready, err}), 64'd0);
    check_val("rst_bus_zero",
              64'({fb_w_xpos, fb_w_ypos, fb_din, fb_r_xpos, fb_r_ypos, fb_r_mode, scan_data}),
              64'd0);
    rst = 1'b0;
  endtask

  task automatic wait_init();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (ready) break;
    end
    check_val("init_ready", 64'(ready), 64'd1);
    @(negedge clk);
    check_val("fb_rst_pulses", 64'(fb_rst_pulses), 64'd1);
    check_val("fb_rst_len", 64'(fb_rst_last_len), 64'd1);
    check_val("ready_after_complete", 64'(ready_cyc - complete_cyc), 64'd1);
  endtask

  int lat_a, lat_b, we_base, ack_base;

  initial begin
    apply_reset();
    wait_init();

    // Both requesters re-raise immediately after each ack
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          scan_go(8'(i + 1), 8'(i + 2), 1'b0, pix(8'(i + 1), 8'(i + 2), 1'b0));
          wait_scan(lat_a);
        end
      end
      begin
        for (int j = 0; j < 4; j++) begin
          draw_go(8'(20 + j), 8'(30 + j), 8'(8'h50 + j));
          wait_draw(lat_b);
        end
      end
    join
    @(negedge clk);
    check_val("grant_count", 64'(grant_log.size()), 64'd8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++)
      check_val($sformatf("grant_order_%0d", k), 64'(grant_log[k]), 64'(k % 2));

    // Column read with late-changing arguments
    rd_force = 1; rd_force_val = 8'hA5;
    scan_go(8'd13, 8'd8, 1'b1, 8'hA5);
    repeat (3) @(negedge clk);
    scan_xpos = 8'd99; scan_ypos = 8'd99; scan_mode = 1'b0;
    @(negedge clk);
    check_val("latched_xpos", 64'(fb_r_xpos), 64'd13);
    check_val("latched_mode", 64'(fb_r_mode), 64'd1);
    wait_scan(lat_a);
    @(negedge clk);
    check_val("read_strobe_len", 64'(last_run), 64'd10);
    rd_force = 0;

    draw_go(8'd10, 8'd20, 8'h3C);
    wait_draw(lat_a);
    @(negedge clk);
    scan_go(8'd5, 8'd6, 1'b0, pix(8'd5, 8'd6, 1'b0));
    wait_scan(lat_a);
    @(negedge clk);

    // Out-of-bounds draws
    we_base = we_rises;
    draw_go(8'd10, 8'd64, 8'hEE);
    wait_draw(lat_a);
    check_val("oob_ack_latency", 64'(lat_a), 64'd1);
    @(negedge clk);
    draw_go(8'd200, 8'd3, 8'h11);
    wait_draw(lat_a);
    @(negedge clk);
    check_val("oob_no_write", 64'(we_rises), 64'(we_base));
    check_val("err_clear_before_timeout", 64'(err), 64'd0);

    // Timeout on a read that never completes
    rd_never = 1;
    scan_go(8'd40, 8'd50, 1'b0, 8'h00);
    wait_scan(lat_a);
    @(negedge clk);
    check_val("timeout_strobe_len", 64'(last_run), 64'd31);
    check_val("timeout_err", 64'(err), 64'd1);
    rd_never = 0;
    scan_go(8'd41, 8'd2, 1'b1, pix(8'd41, 8'd2, 1'b1));
    wait_scan(lat_a);
    @(negedge clk);
    check_val("err_sticky", 64'(err), 64'd1);

    // Reset in the middle of a write; request stays pending through re-init
    wr_never = 1;
    draw_go(8'd30, 8'd40, 8'h77);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fb_we) break;
    end
    check_val("write_started", 64'(fb_we), 64'd1);
    @(negedge clk);
    ack_base = draw_acks;
    draw_q.delete();
    apply_reset();
    wr_never = 0;
    draw_go(8'd30, 8'd40, 8'h77);
    wait_init();
    check_val("no_ack_abandoned", 64'(draw_acks), 64'(ack_base));
    wait_draw(lat_a);
    @(negedge clk);

    check_val("scan_q_drained", 64'(scan_q.size()), 64'd0);
    check_val("draw_q_drained", 64'(draw_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
